// File: rtl/lock_supervisor.sv
// lock_supervisor: lockout after repeated wrong entries, door-ajar flag, key-strobe gating.
// Define LOCK_ALARM_EN to escalate a repeat lockout into an ALARM state cleared by SET.
module lock_supervisor #(
    parameter int unsigned MAX_WRONG      = 3,
    parameter logic [31:0] LOCKOUT_CYCLES = 32'd250_000_000,
    parameter logic [31:0] OPEN_TIMEOUT   = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       reset_1,
    input  logic       key_valid_in,
    input  logic [3:0] count_Wrong,
    input  logic       OPEN,
    input  logic       SET,
    output logic       key_valid_out,
    output logic       lockout,
    output logic       alarm,
    output logic       door_ajar,
    output logic [2:0] strikes
);

    typedef enum logic [3:0] {
        ARMED   = 4'b0001,
        LOCKOUT = 4'b0010,
        OPENED  = 4'b0100,
        ALARM   = 4'b1000
    } state_t;

    localparam int unsigned IA = 0;
    localparam int unsigned IL = 1;
    localparam int unsigned IO = 2;
    localparam logic [3:0]  MW = 4'(MAX_WRONG);

    state_t      state_q;
    logic [31:0] timer_q;
    logic [3:0]  cw_q;
    logic        open_q;
    logic        gate_q;
    logic        wrong_evt;
    logic        open_rise;
    logic        hit;
    logic        to_block;
    logic        to_free;
    logic        gate_d;

`ifdef LOCK_ALARM_EN
    localparam int unsigned IX = 3;
    logic [1:0] lock_cnt_q;
`else
    logic unused_set;
    assign unused_set = SET;
    assign alarm      = 1'b0;
`endif

    assign key_valid_out = key_valid_in & gate_q;

    always_comb begin
        wrong_evt = (count_Wrong != cw_q) && (count_Wrong != 4'd0);
        open_rise = OPEN && !open_q;
        hit       = ({1'b0, strikes} + 4'd1) >= MW;
        to_block  = state_q[IA] && !open_rise && wrong_evt && hit;
        to_free   = state_q[IL] && (timer_q == 32'd0);
`ifdef LOCK_ALARM_EN
        to_free   = to_free || (state_q[IX] && SET);
`endif
        // Gate follows the state being entered so no strobe slips out
        // during the first blocked cycle.
        if (to_block) begin
            gate_d = 1'b0;
        end else if (to_free) begin
            gate_d = 1'b1;
        end else begin
            gate_d = state_q[IA] | state_q[IO];
        end
    end

    always_ff @(posedge clk or negedge reset_1) begin
        if (!reset_1) begin
            state_q    <= ARMED;
            timer_q    <= '0;
            cw_q       <= '0;
            open_q     <= 1'b0;
            gate_q     <= 1'b1;
            strikes    <= '0;
            lockout    <= 1'b0;
            door_ajar  <= 1'b0;
`ifdef LOCK_ALARM_EN
            lock_cnt_q <= '0;
            alarm      <= 1'b0;
`endif
        end else begin
            cw_q   <= count_Wrong;
            open_q <= OPEN;
            if (!key_valid_in) begin
                gate_q <= gate_d;
            end
            unique case (1'b1)
                state_q[IA]: begin
                    if (open_rise) begin
                        state_q    <= OPENED;
                        timer_q    <= OPEN_TIMEOUT - 32'd1;
                        strikes    <= '0;
`ifdef LOCK_ALARM_EN
                        lock_cnt_q <= '0;
`endif
                    end else if (wrong_evt) begin
                        strikes <= (strikes == 3'd7) ? 3'd7 : strikes + 3'd1;
                        if (hit) begin
`ifdef LOCK_ALARM_EN
                            if (lock_cnt_q != 2'd0) begin
                                state_q <= ALARM;
                                alarm   <= 1'b1;
                            end else begin
                                state_q <= LOCKOUT;
                                timer_q <= LOCKOUT_CYCLES - 32'd1;
                                lockout <= 1'b1;
                            end
                            if (lock_cnt_q != 2'd3) begin
                                lock_cnt_q <= lock_cnt_q + 2'd1;
                            end
`else
                            state_q <= LOCKOUT;
                            timer_q <= LOCKOUT_CYCLES - 32'd1;
                            lockout <= 1'b1;
`endif
                        end
                    end
                end
                state_q[IL]: begin
                    if (timer_q == 32'd0) begin
                        state_q <= ARMED;
                        lockout <= 1'b0;
                        strikes <= '0;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                state_q[IO]: begin
                    if (!OPEN) begin
                        state_q   <= ARMED;
                        door_ajar <= 1'b0;
                    end else if (timer_q == 32'd0) begin
                        door_ajar <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
`ifdef LOCK_ALARM_EN
                state_q[IX]: begin
                    if (SET) begin
                        state_q    <= ARMED;
                        alarm      <= 1'b0;
                        strikes    <= '0;
                        lock_cnt_q <= '0;
                    end
                end
`endif
                default: begin
                    state_q <= ARMED;
                end
            endcase
        end
    end

endmodule

// File: doc/lock_supervisor.md
# lock_supervisor

Security supervisor for the keypad lock: sits between the key scanner and the password decider. It counts failed attempts reported by the decider, blocks key entry for a fixed lockout window after too many failures, and flags a door held open too long. It does not touch the decider's password storage; it only gates the scanner's key-valid strobe and drives status LEDs.

## Interface
- MAX_WRONG, 3: consecutive wrong entries that trigger lockout; legal range 1..7.
- LOCKOUT_CYCLES, 32'd250_000_000: lockout duration in clk cycles; must be ≥1.
- OPEN_TIMEOUT, 32'd500_000_000: cycles OPEN may stay high before door_ajar asserts; must be ≥1.
- clk  in  1  system clock, same domain as the decider.
- reset_1  in  1  asynchronous, active-low reset.
- key_valid_in  in  1  raw key-valid strobe from the scanner.
- count_Wrong  in  4  decider's wrong-attempt counter.
- OPEN  in  1  decider open indication.
- SET  in  1  decider set-mode indication, used as the administrator acknowledge.
- key_valid_out  out  1  gated strobe to the decider's Valid_1.
- lockout  out  1  high while key entry is blocked by lockout.
- alarm  out  1  escalation alarm; tied 0 without LOCK_ALARM_EN.
- door_ajar  out  1  OPEN has exceeded OPEN_TIMEOUT.
- strikes  out  3  current consecutive wrong count.

## Operation
- **State machine (one-hot):** ARMED, LOCKOUT, OPENED, ALARM. Reset state is ARMED.
- **Wrong event (wrong_evt):** asserted when count_Wrong ≠ cw_q and count_Wrong ≠ 0.
  - cw_q is a register that samples count_Wrong every clk; its reset value is 0.
  - A decider clear to 0, or a 15→0 wrap, is not an event.
- **ARMED:**
  - wrong_evt increments strikes, saturating at 7.
  - If strikes+1 ≥ MAX_WRONG, go to LOCKOUT. Load timer with LOCKOUT_CYCLES−1 and increment lock_cnt (2-bit, saturating).
  - A rising OPEN (OPEN & !open_q) goes to OPENED. Load timer with OPEN_TIMEOUT−1, clear strikes, clear lock_cnt.
  - OPEN rise and wrong_evt in the same cycle: OPEN wins.
- **LOCKOUT:**
  - Timer decrements each cycle. The cycle after timer reaches 0, go to ARMED and clear strikes.
  - wrong_evt (an in-flight key) and OPEN are ignored.
- **OPENED:**
  - Timer decrements, saturating at 0. door_ajar is set when timer==0 and OPEN is high.
  - OPEN low goes to ARMED and clears door_ajar.
  - wrong_evt here updates cw_q only.
- **ALARM:** only exists with LOCK_ALARM_EN. Keys are blocked. SET high goes to ARMED and clears strikes and lock_cnt.
- **Key gating:**
  - key_valid_out = key_valid_in & gate_q.
  - gate_q = 1 in ARMED/OPENED and 0 in LOCKOUT/ALARM.
  - gate_q updates only on cycles where key_valid_in is low, so a strobe in progress is never truncated or started mid-pulse.
- **Reset mid-operation:** all state, timer, strikes and lock_cnt clear immediately; gate_q resets to 1.

## Timing
- Reset values:
  - key_valid_out follows key_valid_in.
  - lockout=0, alarm=0, door_ajar=0, strikes=0.
- State, strikes, lockout, alarm and door_ajar are registered (Moore outputs).
- lockout rises on the same clk edge that first samples the offending count_Wrong value.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- door_ajar rises OPEN_TIMEOUT cycles after the edge that entered OPENED.
- key_valid_out is combinational from key_valid_in: zero latency, at most one pulse delayed in gating.
- Timer is 32 bits wide. Parameters are compared unsigned.

## Configuration
- LOCK_ALARM_EN defined:
  - Reaching MAX_WRONG while lock_cnt ≥ 1 (a second lockout with no successful open in between) goes to ALARM instead of LOCKOUT.
  - alarm = 1 in ALARM.
- LOCK_ALARM_EN undefined:
  - ALARM state and lock_cnt logic are omitted, and alarm is tied 0.
  - Every MAX_WRONG hit enters LOCKOUT.

## Test plan
All scenarios use MAX_WRONG=3, LOCKOUT_CYCLES=20, OPEN_TIMEOUT=50.
- count_Wrong steps 0→1→2→3 → strikes 1,2 then lockout=1 for exactly 20 cycles; key_valid_out stays 0 throughout; strikes=0 after exit.
- key_valid_in high when lockout is entered → key_valid_out finishes that pulse; the next pulse is blocked; after exit, the first new pulse passes.
- OPEN rises → strikes=0. OPEN held 60 cycles → door_ajar=1 at cycle 50, drops the cycle after OPEN falls.
- OPEN rise and count_Wrong change in the same cycle → state OPENED, strikes=0, lockout=0.
- LOCK_ALARM_EN, two lockouts with no open in between → alarm=1 and keys blocked; SET=1 → alarm=0 and strikes=0. Without the macro, the same stimulus → second LOCKOUT and alarm=0.
- reset_1 low midway through LOCKOUT → all outputs return to reset values asynchronously; no lockout after release.
